// File: rtl/cpu_boot_pkg.sv
// Shared types for the CPU boot loader.
//   boot_state_t : loader sequencer states
//   boot_err_t   : error cause reported on err_code while in ERROR
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        HOLD,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        RELEASE,
        RUN,
        ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        E_NONE,
        E_CSUM,
        E_LEN,
        E_TIMEOUT
    } boot_err_t;

    // Width of the inter-byte idle counter.
    localparam int IDLE_W = 20;

endpackage

// File: rtl/cpu_boot_loader.sv
// Boot sequencer: keeps the CPU in reset while a program image arrives as a
// byte stream, packs the payload into 32-bit little-endian words, writes them
// to the instruction ROM, checks the image checksum and then releases the CPU.
// A load request while running (or after an error) restarts the sequence.
//
// Image: LEN_HI, LEN_LO (word count N, big-endian), 4*N payload bytes, CHK.
// Good image: 8-bit sum of payload bytes plus CHK equals zero.
//
// Byte handshake: a byte moves when rx_valid and rx_ready are both high on a
// rising clk edge; rx_data must be stable while rx_valid is high and the
// loader never consumes a byte while rx_ready is low.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   rx_valid/rx_data      incoming byte stream
//   rx_ready              loader can take a byte (LEN_HI, LEN_LO, DATA, CHK)
//   load_req              level, restarts loading from RUN or ERROR
//   rom_we/waddr/wdata    ROM write port, one strobe per assembled word
//   cpu_resetN            CPU reset, high only in RUN
//   busy                  high from HOLD through CHK
//   done                  one-cycle pulse on the first RUN cycle
//   err/err_code          in ERROR, with the cause held on err_code
module cpu_boot_loader
    import cpu_boot_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [31:0]           rom_wdata,
    output logic                  cpu_resetN,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    boot_state_t             state, next_state;
    boot_err_t               err_q, err_next;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [IDLE_W-1:0]       idle_cnt;
    logic [7:0]              len_hi;
    logic [ADDR_WIDTH:0]     n_words;     // one bit wider: N may equal 2**ADDR_WIDTH
    logic [ADDR_WIDTH:0]     word_cnt;    // words fully assembled so far
    logic [1:0]              byte_idx;
    logic [23:0]             shreg;       // first three bytes of the current word
    logic [7:0]              sum;

    logic                    accept;
    logic                    counting;
    logic                    timeout_hit;
    logic                    word_done;
    logic                    last_word;
    logic [16:0]             len_ext;
    logic                    len_too_big;
    logic [7:0]              chk_total;

    assign rx_ready   = (state inside {LEN_HI, LEN_LO, DATA, CHK});
    assign accept     = rx_valid & rx_ready;
    assign cpu_resetN = (state == RUN);
    assign busy       = (state inside {HOLD, LEN_HI, LEN_LO, DATA, CHK});
    assign err        = (state == ERROR);
    assign err_code   = err_q;

    // The idle counter only runs while mid-image; an accept on the expiry
    // cycle takes priority over the timeout.
    assign counting    = (state inside {LEN_LO, DATA, CHK});
    assign timeout_hit = counting && (idle_cnt == IDLE_LAST) && !accept;

    assign len_ext     = {1'b0, len_hi, rx_data};
    assign len_too_big = ({15'd0, len_ext} > (32'd1 << ADDR_WIDTH));
    assign word_done   = accept && (state == DATA) && (byte_idx == 2'd3);
    assign last_word   = word_done && ((word_cnt + 1'b1) == n_words);
    assign chk_total   = sum + rx_data;

    always_comb begin
        next_state = state;
        err_next   = E_NONE;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_too_big) begin
                        next_state = ERROR;
                        err_next   = E_LEN;
                    end else if (len_ext == 17'd0) begin
                        next_state = CHK;
                    end else begin
                        next_state = DATA;
                    end
                end else if (timeout_hit) begin
                    next_state = ERROR;
                    err_next   = E_TIMEOUT;
                end
            end
            DATA: begin
                if (last_word) begin
                    next_state = CHK;
                end else if (timeout_hit) begin
                    next_state = ERROR;
                    err_next   = E_TIMEOUT;
                end
            end
            CHK: begin
                if (accept) begin
                    if (chk_total == 8'h00) begin
                        next_state = RELEASE;
                    end else begin
                        next_state = ERROR;
                        err_next   = E_CSUM;
                    end
                end else if (timeout_hit) begin
                    next_state = ERROR;
                    err_next   = E_TIMEOUT;
                end
            end
            RELEASE: next_state = RUN;
            RUN:     if (load_req) next_state = HOLD;
            ERROR:   if (load_req) next_state = HOLD;
            default: next_state = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            err_q     <= E_NONE;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            len_hi    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            sum       <= '0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            done      <= 1'b0;
        end else begin
            state  <= next_state;
            rom_we <= word_done;
            done   <= (state == RELEASE);

            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            idle_cnt <= (accept || !counting) ? '0 : idle_cnt + 1'b1;

            if (next_state == HOLD) begin
                err_q <= E_NONE;
            end else if (next_state == ERROR && state != ERROR) begin
                err_q <= err_next;
            end

            if (state == HOLD) begin
                sum       <= '0;
                word_cnt  <= '0;
                byte_idx  <= '0;
                rom_waddr <= '0;
            end

            if (accept && state == LEN_HI) len_hi <= rx_data;
            if (accept && state == LEN_LO) n_words <= len_ext[ADDR_WIDTH:0];

            if (accept && state == DATA) begin
                sum      <= sum + rx_data;
                byte_idx <= byte_idx + 1'b1;
                shreg    <= {rx_data, shreg[23:8]};
                if (byte_idx == 2'd3) begin
                    rom_wdata <= {rx_data, shreg};
                    word_cnt  <= word_cnt + 1'b1;
                end
            end

            // Advance the address once the strobe has gone out, except after
            // the final word so a full-size image leaves it on the top entry.
            if (rom_we && word_cnt != n_words) rom_waddr <= rom_waddr + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader, built with a 4-bit ROM address, a 16-cycle idle
// timeout and a 4-cycle hold so the size and timeout limits are reachable.
module tb_cpu_boot_loader;

    localparam int AW = 4;
    localparam int TO = 16;
    localparam int HC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          load_req;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          cpu_resetN;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] exp_q[$];     // expected ROM writes {addr, data}, in order
    logic [31:0]    img [0:31];   // payload words of the image being sent
    logic           prev_rstn = 1'b0;

    always #5 clk = ~clk;

    cpu_boot_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .load_req  (load_req),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .cpu_resetN(cpu_resetN),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: checksum byte that makes the payload of img[0..n-1] sum to zero.
    function automatic logic [7:0] chk_for(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                s = s + img[i][8*k +: 8];
        return 8'h00 - s;
    endfunction

    // Compare process: ROM writes against the scoreboard, plus the output
    // relations that hold in every cycle.
    always @(negedge clk) begin
        logic [AW+31:0] w;
        if (!reset) begin
            if (rom_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rom_write_unexpected: got addr %0h data %0h, expected no write",
                             rom_waddr, rom_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("rom_write", {rom_waddr, rom_wdata}, w);
                end
            end
            check("done_on_release", done, cpu_resetN & ~prev_rstn);
            check("cpu_free_only_idle", cpu_resetN & (busy | err), 1'b0);
            check("ready_only_busy", rx_ready & ~busy, 1'b0);
            check("err_vs_err_code", err, err_code != 2'd0);
        end
        prev_rstn = cpu_resetN;
    end

    // Called at a negedge; offers one byte and returns at the negedge just
    // after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_stall: rx_ready low for %0d cycles, expected 1", guard);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input int n, input logic [7:0] delta, input int gap_lo, input int gap_hi);
        logic [7:0] bytes[$];
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) bytes.push_back(img[i][8*k +: 8]);
            exp_q.push_back({AW'(i), img[i]});
        end
        bytes.push_back(chk_for(n) + delta);
        foreach (bytes[j]) begin
            send_byte(bytes[j]);
            if (j != bytes.size() - 1) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
        end
    endtask

    task automatic wait_outcome(input string name, input logic exp_done, input logic [1:0] exp_code);
        int guard = 0;
        while (!done && !err && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_done"}, done, exp_done);
        check({name, "_err_code"}, err_code, exp_code);
        check({name, "_cpu_resetN"}, cpu_resetN, exp_done);
        check({name, "_writes_left"}, exp_q.size(), 0);
    endtask

    // Called at the first negedge in HOLD; counts cycles until bytes are taken.
    task automatic wait_hold(input string name);
        int n = 0;
        check({name, "_hold_busy"}, busy, 1'b1);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_hold_len"}, n, HC);
    endtask

    task automatic reload(input string name);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check({name, "_cpu_resetN_low"}, cpu_resetN, 1'b0);
        check({name, "_err_cleared"}, {err, err_code}, 3'd0);
        wait_hold(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cpu_resetN", cpu_resetN, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_done_err", {done, err, err_code}, 4'd0);
        check("rst_rom", {rom_we, rom_waddr, rom_wdata}, 37'd0);
        reset = 1'b0;
        wait_hold("rst");

        // One word: 0x78+0x56+0x34+0x12 = 0x114, so the checksum byte is 0xEC
        img[0] = 32'h12345678;
        check("t1_model_chk", chk_for(1), 8'hEC);
        send_image(1, 8'h00, 0, 0);
        wait_outcome("t1", 1'b1, 2'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        check("run_not_ready", rx_ready, 1'b0);
        rx_valid = 1'b0;

        // Zero-length image
        reload("t3");
        check("t3_model_chk", chk_for(0), 8'h00);
        send_image(0, 8'h00, 0, 0);
        wait_outcome("t3", 1'b1, 2'd0);

        // Largest image: 16 words, last at address 15, short random gaps
        reload("tmax");
        for (int i = 0; i < 16; i++) img[i] = {$urandom_range(255, 0), $urandom_range(65535, 0), 8'(i)};
        send_image(16, 8'h00, 0, 3);
        wait_outcome("tmax", 1'b1, 2'd0);

        // Long wait in LEN_HI, then 15 idle cycles between bytes: each byte
        // lands on the expiry cycle and must win over the timeout
        reload("tgap");
        repeat (30) @(negedge clk);
        check("tgap_len_hi_no_timeout", {err, rx_ready}, 2'b01);
        img[0] = 32'hCAFEF00D;
        send_image(1, 8'h00, TO - 1, TO - 1);
        wait_outcome("tgap", 1'b1, 2'd0);

        // Two words with a wrong checksum byte
        reload("t2");
        img[0] = 32'h00000001;
        img[1] = 32'h00000002;
        check("t2_model_chk", chk_for(2), 8'hFD);
        send_image(2, 8'h01, 0, 1);
        wait_outcome("t2", 1'b0, 2'd1);
        repeat (3) @(negedge clk);
        check("t2_err_held", {err, err_code, cpu_resetN}, 4'b1010);

        // Length 17 exceeds 16 entries
        reload("t4");
        send_byte(8'h00);
        send_byte(8'h11);
        check("t4_len_err", {err, err_code}, 3'b110);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (2) @(negedge clk);
        check("t4_err_not_ready", {rx_ready, err}, 2'b01);
        rx_valid = 1'b0;

        // Stall after two payload bytes: error 16 cycles after that accept
        reload("t5");
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TO - 1) @(negedge clk);
        check("t5_before_timeout", err, 1'b0);
        @(negedge clk);
        check("t5_timeout", {err, err_code}, 3'b111);
        check("t5_no_write", exp_q.size(), 0);

        // Reset mid-DATA after one word was written
        reload("t6");
        img[0] = 32'hAABBCCDD;
        exp_q.push_back({AW'(0), img[0]});
        send_byte(8'h00);
        send_byte(8'h02);
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8]);
        send_byte(8'h99);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_state", {err, busy, rx_ready, cpu_resetN, rom_we}, 5'b01000);
        reset = 1'b0;
        wait_hold("t6");
        check("t6_word_kept", exp_q.size(), 0);

        // Clean load after the mid-image reset
        img[0] = 32'h01020304;
        img[1] = 32'hFFFFFFFF;
        send_image(2, 8'h00, 0, 2);
        wait_outcome("t6b", 1'b1, 2'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
